// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } uart_arb_state_e;

  localparam int          UART_NREQ_DEF    = 4;
  localparam logic [15:0] UART_TIMEOUT_DEF = 16'hFFFF;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester and transmitter handshake bundle; slave is the arbiter side, master the environment side.
interface uart_tx_arb_if
  import uart_pkg::*;
#(
  parameter int NREQ = UART_NREQ_DEF
) ();

  logic [NREQ-1:0]         req_valid;
  logic [8*NREQ-1:0]       req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    tnsm;
  logic [7:0]              tnsm_data;
  logic                    tnsm_clr;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic                    grant_active;
  logic                    done;
  logic                    err_timeout;

  modport slave (
    input  req_valid, req_data, tnsm_clr, busy,
    output req_ready, tnsm, tnsm_data, grant_id, grant_active, done, err_timeout
  );

  modport master (
    output req_valid, req_data, tnsm_clr, busy,
    input  req_ready, tnsm, tnsm_data, grant_id, grant_active, done, err_timeout
  );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Stateless round-robin pick: first set request scanning upward from last_grant+1, wrapping at NREQ.
module uart_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  always_comb begin
    logic [IW-1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(last_grant) + i) % NREQ);
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates NREQ byte requesters onto one UART transmitter; accept in IDLE, req_ready->tnsm 1 cycle.
// Backpressure: requesters wait in IDLE; LOAD stalls until tnsm_clr or TIMEOUT, SEND until busy drops.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int          NREQ    = UART_NREQ_DEF,
  parameter logic [15:0] TIMEOUT = UART_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  uart_tx_arb_if.slave bus
);

  localparam int          IW       = $clog2(NREQ);
  localparam logic [1:0]  IDLE     = ST_IDLE;
  localparam logic [1:0]  LOAD     = ST_LOAD;
  localparam logic [1:0]  SEND     = ST_SEND;
  localparam logic [1:0]  DONE     = ST_DONE;
  localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

  logic [1:0]    state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [15:0]   tmo_cnt_q, tmo_cnt_d;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  uart_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  // Outputs are decoded from state and forced low while rst is held, even before the reset edge.
  always_comb begin
    state_d          = state_q;
    data_d           = data_q;
    grant_id_d       = grant_id_q;
    last_grant_d     = last_grant_q;
    tmo_cnt_d        = '0;
    bus.req_ready    = '0;
    bus.tnsm         = 1'b0;
    bus.tnsm_data    = '0;
    bus.grant_active = 1'b0;
    bus.done         = 1'b0;
    bus.err_timeout  = 1'b0;
    bus.grant_id     = rst ? '0 : grant_id_q;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            bus.req_ready = arb_grant;
            data_d        = bus.req_data[{arb_idx, 3'b000} +: 8];
            grant_id_d    = arb_idx;
            state_d       = LOAD;
          end
        end
        LOAD: begin
          bus.tnsm         = 1'b1;
          bus.tnsm_data    = data_q;
          bus.grant_active = 1'b1;
          // An acknowledge on the last allowed cycle still counts as success.
          if (bus.tnsm_clr) begin
            state_d = SEND;
          end else if (tmo_cnt_q == TMO_LAST) begin
            bus.err_timeout = 1'b1;
            last_grant_d    = grant_id_q;
            state_d         = IDLE;
          end else begin
            tmo_cnt_d = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
          end
        end
        SEND: begin
          bus.grant_active = 1'b1;
          if (!bus.busy) begin
            state_d = DONE;
          end
        end
        default: begin
          bus.done     = 1'b1;
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      grant_id_q   <= '0;
      last_grant_q <= IW'(NREQ - 1);
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a transaction-level reference model and a transmitter responder.
module tb_uart_tx_arb;

  localparam int NREQ = 4;
  localparam int TMO  = 10;

  logic clk;
  logic rst;

  uart_tx_arb_if #(.NREQ(NREQ)) bus ();

  uart_tx_arb #(.NREQ(NREQ), .TIMEOUT(16'd10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Transmitter responder controls: acknowledge after clr_delay tnsm cycles (-1 = never).
  int clr_delay = 3;
  int tx_seen   = 0;
  int busy_left = 0;

  // Reference model: owner < 0 means no frame in flight.
  int         m_owner = -1;
  int         m_load  = -1;
  bit         m_send  = 1'b0;
  int         m_last  = NREQ - 1;
  int         m_gid   = 0;
  logic [7:0] m_byte  = 8'h00;

  logic [3:0] e_rdy;
  logic [7:0] e_dat;
  logic       e_tnsm, e_gact, e_done, e_err;
  int         e_gid;
  int         w;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int last);
    for (int i = 1; i <= NREQ; i++) begin
      if (v[(last + i) % NREQ]) return (last + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Waits (bounded) for an event; n returns the number of cycles waited.
  task automatic wait_ev(input int sel, input string nm, output int n);
    bit hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       hit = (bus.req_ready != '0);
        1:       hit = bus.tnsm;
        2:       hit = bus.done;
        3:       hit = bus.err_timeout;
        default: hit = bus.grant_active && !bus.tnsm;
      endcase
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL %s: event not seen within 200 cycles", nm);
    end
  endtask

  // Transmitter responder.
  initial begin
    bus.tnsm_clr = 1'b0;
    bus.busy     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_seen == clr_delay) begin
        bus.tnsm_clr = 1'b1;
        busy_left    = 20;
      end else begin
        bus.tnsm_clr = 1'b0;
      end
      bus.busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      tx_seen = bus.tnsm ? tx_seen + 1 : 0;
    end
  end

  // Compare process: expected outputs this cycle from the model, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      e_rdy  = '0;
      e_dat  = '0;
      e_tnsm = 1'b0;
      e_gact = 1'b0;
      e_done = 1'b0;
      e_err  = 1'b0;
      e_gid  = m_gid;
      if (rst) begin
        m_owner = -1;
        m_load  = -1;
        m_send  = 1'b0;
        m_last  = NREQ - 1;
        m_gid   = 0;
        m_byte  = 8'h00;
      end else if (m_owner < 0) begin
        w = pick(bus.req_valid, m_last);
        if (w >= 0) begin
          e_rdy[w] = 1'b1;
          m_owner  = w;
          m_gid    = w;
          m_byte   = bus.req_data[8*w +: 8];
          m_load   = 0;
        end
      end else if (m_load >= 0) begin
        e_tnsm = 1'b1;
        e_dat  = m_byte;
        e_gact = 1'b1;
        if (bus.tnsm_clr) begin
          m_load = -1;
          m_send = 1'b1;
        end else if (m_load == TMO - 1) begin
          e_err   = 1'b1;
          m_last  = m_owner;
          m_owner = -1;
          m_load  = -1;
        end else begin
          m_load++;
        end
      end else if (m_send) begin
        e_gact = 1'b1;
        if (!bus.busy) m_send = 1'b0;
      end else begin
        e_done  = 1'b1;
        m_last  = m_owner;
        m_owner = -1;
      end
      chk("cyc_req_ready", bus.req_ready, e_rdy);
      chk("cyc_tnsm", bus.tnsm, e_tnsm);
      chk("cyc_tnsm_data", bus.tnsm_data, e_dat);
      chk("cyc_grant_active", bus.grant_active, e_gact);
      chk("cyc_done", bus.done, e_done);
      chk("cyc_err_timeout", bus.err_timeout, e_err);
      if (!rst) chk("cyc_grant_id", bus.grant_id, e_gid);
    end
  end

  initial begin
    int n;
    int order[$];
    int exp_order[8];
    int tn, er, dn;
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tnsm", bus.tnsm, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_gact", bus.grant_active, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_gid", bus.grant_id, 0);
    chk("idle_ready", bus.req_ready, 0);

    // Single request from requester 2.
    @(posedge clk); #1;
    bus.req_valid          = 4'b0100;
    bus.req_data[23:16]    = 8'hA5;
    wait_ev(0, "a_ready", n);
    chk("a_ready", bus.req_ready, 4'b0100);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_ev(1, "a_tnsm", n);
    chk("a_data", bus.tnsm_data, 8'hA5);
    chk("a_gid", bus.grant_id, 2);
    wait_ev(2, "a_done", n);
    chk("a_done_lat", n, 24);

    // Fairness with all four requesting, starting from a fresh reset.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bus.req_data  = 32'h44332211;
    bus.req_valid = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      wait_ev(0, "b_ready", n);
      order.push_back(oh2i(bus.req_ready));
      if (f > 0) chk("b_gap", n, 26);
    end
    @(posedge clk); #1 bus.req_valid = '0;
    wait_ev(2, "b_done", n);
    for (int i = 0; i < 8; i++) begin
      chk("b_order", (i < order.size()) ? order[i] : -1, exp_order[i]);
    end

    // Timeout with no acknowledge, then the next requester is served.
    clr_delay     = -1;
    bus.req_valid = 4'b0011;
    wait_ev(0, "c_ready", n);
    chk("c_ready", bus.req_ready, 4'b0001);
    wait_ev(3, "c_err", n);
    chk("c_err_lat", n, 10);
    wait_ev(0, "c_next", n);
    chk("c_next_ready", bus.req_ready, 4'b0010);
    chk("c_next_gap", n, 1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    clr_delay     = 3;
    wait_ev(2, "c_done", n);

    // Accepted byte must not follow later req_data changes.
    @(posedge clk); #1;
    bus.req_data[7:0] = 8'h3C;
    bus.req_valid     = 4'b0001;
    wait_ev(0, "d_ready", n);
    chk("d_ready", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    bus.req_data[7:0] = 8'hFF;
    bus.req_valid     = '0;
    wait_ev(1, "d_tnsm", n);
    n = 0;
    while (bus.tnsm && n < 20) begin
      chk("d_data", bus.tnsm_data, 8'h3C);
      @(negedge clk);
      n++;
    end
    chk("d_load_len", n, 4);
    wait_ev(2, "d_done", n);

    // Acknowledge on the last allowed LOAD cycle wins over the timeout.
    @(posedge clk); #1;
    clr_delay           = 9;
    bus.req_data[23:16] = 8'h5A;
    bus.req_valid       = 4'b0100;
    wait_ev(0, "e_ready", n);
    chk("e_ready", bus.req_ready, 4'b0100);
    @(posedge clk); #1 bus.req_valid = '0;
    tn = 0; er = 0; dn = 0;
    for (int c = 0; c < 60 && dn == 0; c++) begin
      @(negedge clk);
      tn += int'(bus.tnsm);
      er += int'(bus.err_timeout);
      dn += int'(bus.done);
    end
    chk("e_load_len", tn, 10);
    chk("e_no_err", er, 0);
    chk("e_done", dn, 1);

    // Reset while the frame is in SEND.
    @(posedge clk); #1;
    clr_delay     = 3;
    bus.req_valid = 4'b1000;
    wait_ev(0, "f_ready", n);
    chk("f_ready", bus.req_ready, 4'b1000);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_ev(4, "f_send", n);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("f_rst_tnsm", bus.tnsm, 0);
    chk("f_rst_data", bus.tnsm_data, 0);
    chk("f_rst_gact", bus.grant_active, 0);
    chk("f_rst_done", bus.done, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("f_post_gact", bus.grant_active, 0);
    chk("f_post_done", bus.done, 0);
    chk("f_post_gid", bus.grant_id, 0);
    @(posedge clk); #1 bus.req_valid = 4'b1111;
    dn = 0;
    n  = 0;
    while (bus.req_ready == '0 && n < 50) begin
      @(negedge clk);
      dn += int'(bus.done);
      n++;
    end
    chk("f_no_done", dn, 0);
    chk("f_first_grant", bus.req_ready, 4'b0001);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_ev(2, "f_done", n);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter NREQ, default 4: number of requesters (2..8).
REQ-003 Parameter TIMEOUT, default 16'hFFFF: maximum LOAD cycles allowed before the transmitter must accept.
REQ-004 clk  in  1  system clock, rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  NREQ  per-requester byte-pending flag.
REQ-007 req_data  in  8*NREQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 req_ready  out  NREQ  one-hot accept strobe; a byte transfers when req_valid[i] and req_ready[i] are both high.
REQ-009 tnsm  out  1  transmit request to the UART transmitter.
REQ-010 tnsm_data  out  8  byte presented to the UART transmitter.
REQ-011 tnsm_clr  in  1  transmitter acknowledge pulse; the transmitter has taken the byte.
REQ-012 busy  in  1  transmitter frame-in-progress flag.
REQ-013 grant_id  out  $clog2(NREQ)  index of the current owner; valid while grant_active is high.
REQ-014 grant_active  out  1  high in LOAD and SEND.
REQ-015 done  out  1  one-cycle pulse when the owner's frame has finished.
REQ-016 err_timeout  out  1  one-cycle pulse when a LOAD times out.

Function
REQ-017 FSM states: IDLE, LOAD, SEND, DONE.
REQ-018 IDLE, no req_valid: all outputs SHALL stay low except grant_id, which holds its value.
REQ-019 IDLE, any req_valid: round-robin winner g = first valid index scanning from last_grant+1 modulo NREQ.
- req_ready[g] is asserted combinationally in that cycle.
- At the edge: data_q <= req_data[g], grant_id <= g, state -> LOAD.
REQ-020 req_ready SHALL be high only in IDLE, and only for the winner; never more than one bit.
REQ-021 LOAD: tnsm = 1, tnsm_data = data_q, and tmo_cnt increments.
- tnsm_clr = 1: state -> SEND and tmo_cnt clears.
- tmo_cnt == TIMEOUT-1 without tnsm_clr: err_timeout pulses, last_grant <= grant_id, state -> IDLE.
REQ-022 tnsm_clr and timeout in the same cycle: tnsm_clr SHALL win (no error, go to SEND).
REQ-023 SEND: tnsm = 0; stay while busy = 1; busy = 0 -> DONE.
REQ-024 DONE: done = 1 for one cycle, last_grant <= grant_id, state -> IDLE.
REQ-025 Minimum spacing between two req_ready pulses SHALL be 4 cycles (IDLE, LOAD, SEND, DONE).
REQ-026 The byte transmitted SHALL be data_q; changes on req_data after acceptance SHALL NOT affect it.
REQ-027 req_valid dropping during LOAD or SEND SHALL NOT abort the transfer.
REQ-028 tnsm_clr or busy seen in IDLE or DONE SHALL be ignored.
REQ-029 tmo_cnt SHALL be 16 bits and saturate; it is not used outside LOAD.

Reset
REQ-030 rst = 1 SHALL, at the next edge and regardless of state, set:
- state = IDLE, last_grant = NREQ-1, so requester 0 wins first;
- data_q = 0, grant_id = 0, tmo_cnt = 0.
REQ-031 While rst = 1, all outputs SHALL be 0: tnsm, tnsm_data, req_ready, grant_active, done, err_timeout.
REQ-032 Reset during LOAD or SEND SHALL drop the transfer silently, with no done and no err_timeout.

Structure
REQ-033 Package uart_pkg SHALL hold uart_arb_state_e (2-bit enum) and the default NREQ and TIMEOUT constants.
REQ-034 Round-robin selection SHALL be a combinational sub-module, uart_rr_arbiter.
- Inputs: req vector, last_grant.
- Outputs: one-hot grant, grant index, any.
REQ-035 All state SHALL be in uart_tx_arb; uart_rr_arbiter holds no state.

Verification
REQ-036 Single request, with a transmitter model asserting tnsm_clr 3 cycles after tnsm and busy for 20 cycles.
- Stimulus: reset released, req_valid = 4'b0100, req_data[2] = 8'hA5.
- Response: req_ready = 4'b0100 for 1 cycle; tnsm_data = 8'hA5 while tnsm = 1; done after busy falls; grant_id = 2.
REQ-037 Round-robin fairness, NREQ = 4.
- Stimulus: all four req_valid held high for 8 frames.
- Response: grant order 0,1,2,3,0,1,2,3.
REQ-038 Timeout, TIMEOUT = 10.
- Stimulus: tnsm_clr held at 0.
- Response: err_timeout pulses on the 10th LOAD cycle; FSM returns to IDLE; the next grant goes to the following requester.
REQ-039 Data stability.
- Stimulus: change req_data[0] to 8'hFF the cycle after req_ready[0].
- Response: tnsm_data stays at the original 8'h3C.
REQ-040 Reset mid-frame.
- Stimulus: assert rst while in SEND.
- Response: next cycle all outputs are 0 and there is no done pulse; the first grant after reset goes to requester 0.
REQ-041 Simultaneous events.
- Stimulus: tnsm_clr arrives on the TIMEOUT-1 cycle.
- Response: FSM enters SEND and err_timeout stays 0.
